// File: rtl/fetch_control.sv
// Program-counter and fetch sequencing stage: sequential/branch/halt PC update,
// Start/Done program handshake, retired-instruction counter and branch-target LUT.
module fetch_control #(
  parameter int PC_W  = 10,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             ResetN,
  input  logic             Start,
  input  logic             Stall,
  input  logic             Halt,
  input  logic             BranchEn,
  input  logic             ConditionalBranch,
  input  logic [4:0]       TargetIdx,
  input  logic             LutWe,
  input  logic [4:0]       LutAddr,
  input  logic [PC_W-1:0]  LutData,
  output logic [PC_W-1:0]  ProgCtr,
  output logic             Running,
  output logic             Done,
  output logic [CNT_W-1:0] InstrCount
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [PC_W-1:0]  pc_next;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] cnt_inc;
  logic             done_next;
  logic [PC_W-1:0]  lut [32];
  logic [PC_W-1:0]  lut_target;

  // Read sees pre-write contents, so a same-cycle write/branch collision uses the old value.
  assign lut_target = lut[TargetIdx];
  assign cnt_inc    = (InstrCount == '1) ? InstrCount : InstrCount + CNT_W'(1);
  assign Running    = (state == RUN);

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      for (int i = 0; i < 32; i++) begin
        lut[i] <= '0;
      end
    end else if (LutWe) begin
      lut[LutAddr] <= LutData;
    end
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state      <= IDLE;
      ProgCtr    <= '0;
      InstrCount <= '0;
      Done       <= 1'b0;
    end else begin
      state      <= state_next;
      ProgCtr    <= pc_next;
      InstrCount <= cnt_next;
      Done       <= done_next;
    end
  end

  always_comb begin
    state_next = state;
    pc_next    = ProgCtr;
    cnt_next   = InstrCount;
    done_next  = Done;
    case (state)
      IDLE, DONE: begin
        if (Start) begin
          pc_next    = '0;
          cnt_next   = '0;
          done_next  = 1'b0;
          state_next = RUN;
        end
      end
      RUN: begin
        // Priority: restart, stall, halt, taken branch, sequential.
        if (Start) begin
          pc_next  = '0;
          cnt_next = '0;
        end else if (Stall) begin
          pc_next = ProgCtr;
        end else if (Halt) begin
          done_next  = 1'b1;
          cnt_next   = cnt_inc;
          state_next = DONE;
        end else if (BranchEn && ConditionalBranch) begin
          pc_next  = lut_target;
          cnt_next = cnt_inc;
        end else begin
          pc_next  = ProgCtr + PC_W'(1);
          cnt_next = cnt_inc;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule
